// File: rtl/regfile_arbiter.sv
// Two-port arbiter in front of a single-ported register file: one transaction at a time, all outputs registered.
// Build option: REGFILE_ARB_FIXED_PRIO_EN makes port 0 win every tie; otherwise ties alternate round-robin.
module regfile_arbiter #(
  parameter int R_ADDR_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    p0_req,
  input  logic                    p0_we,
  input  logic [R_ADDR_WIDTH-1:0] p0_addr,
  input  logic [31:0]             p0_wdata,
  output logic                    p0_ack,
  output logic [31:0]             p0_rdata,

  input  logic                    p1_req,
  input  logic                    p1_we,
  input  logic [R_ADDR_WIDTH-1:0] p1_addr,
  input  logic [31:0]             p1_wdata,
  output logic                    p1_ack,
  output logic [31:0]             p1_rdata,

  output logic                    o_rd,
  output logic [R_ADDR_WIDTH-1:0] o_rreg,
  input  logic [31:0]             i_rdata,
  output logic                    o_wr,
  output logic [R_ADDR_WIDTH-1:0] o_wreg,
  output logic [31:0]             o_wdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    RD_ISSUE = 2'd2,
    RD_DONE  = 2'd3
  } state_e;

  // gnt_port_q remembers which port owns the transaction in flight; in round-robin
  // builds it is also the last grant, reset to 1 so port 0 wins the first tie.
`ifdef REGFILE_ARB_FIXED_PRIO_EN
  localparam logic GNT_RST = 1'b0;
`else
  localparam logic GNT_RST = 1'b1;
`endif

  state_e                  state_q, state_d;
  logic                    gnt_port_q, gnt_port_d;
  logic                    o_rd_q, o_rd_d;
  logic                    o_wr_q, o_wr_d;
  logic [R_ADDR_WIDTH-1:0] o_rreg_q, o_rreg_d;
  logic [R_ADDR_WIDTH-1:0] o_wreg_q, o_wreg_d;
  logic [31:0]             o_wdata_q, o_wdata_d;
  logic                    p0_ack_q, p0_ack_d;
  logic                    p1_ack_q, p1_ack_d;
  logic [31:0]             p0_rdata_q, p0_rdata_d;
  logic [31:0]             p1_rdata_q, p1_rdata_d;

  logic                    any_req;
  logic                    sel_port;
  logic                    sel_we;
  logic [R_ADDR_WIDTH-1:0] sel_addr;
  logic [31:0]             sel_wdata;

  always_comb begin
    any_req = p0_req | p1_req;
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    sel_port = ~p0_req;
`else
    if (p0_req && p1_req) begin
      sel_port = ~gnt_port_q;
    end else begin
      sel_port = ~p0_req;
    end
`endif
    sel_we    = sel_port ? p1_we    : p0_we;
    sel_addr  = sel_port ? p1_addr  : p0_addr;
    sel_wdata = sel_port ? p1_wdata : p0_wdata;
  end

  always_comb begin
    state_d    = state_q;
    gnt_port_d = gnt_port_q;
    o_rd_d     = 1'b0;
    o_wr_d     = 1'b0;
    o_rreg_d   = o_rreg_q;
    o_wreg_d   = o_wreg_q;
    o_wdata_d  = o_wdata_q;
    p0_ack_d   = 1'b0;
    p1_ack_d   = 1'b0;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_port_d = sel_port;
          if (sel_we) begin
            // Writes complete in the same cycle the strobe is issued.
            state_d   = WRITE;
            o_wr_d    = 1'b1;
            o_wreg_d  = sel_addr;
            o_wdata_d = sel_wdata;
            p0_ack_d  = ~sel_port;
            p1_ack_d  = sel_port;
          end else begin
            state_d  = RD_ISSUE;
            o_rd_d   = 1'b1;
            o_rreg_d = sel_addr;
          end
        end
      end
      RD_ISSUE: begin
        state_d = RD_DONE;
        if (gnt_port_q) begin
          p1_rdata_d = i_rdata;
          p1_ack_d   = 1'b1;
        end else begin
          p0_rdata_d = i_rdata;
          p0_ack_d   = 1'b1;
        end
      end
      // Ack cycle: requests are not sampled so a still-high req is not issued twice.
      WRITE, RD_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_port_q <= GNT_RST;
      o_rd_q     <= 1'b0;
      o_wr_q     <= 1'b0;
      o_rreg_q   <= '0;
      o_wreg_q   <= '0;
      o_wdata_q  <= 32'd0;
      p0_ack_q   <= 1'b0;
      p1_ack_q   <= 1'b0;
      p0_rdata_q <= 32'd0;
      p1_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      gnt_port_q <= gnt_port_d;
      o_rd_q     <= o_rd_d;
      o_wr_q     <= o_wr_d;
      o_rreg_q   <= o_rreg_d;
      o_wreg_q   <= o_wreg_d;
      o_wdata_q  <= o_wdata_d;
      p0_ack_q   <= p0_ack_d;
      p1_ack_q   <= p1_ack_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
    end
  end

  assign o_rd     = o_rd_q;
  assign o_wr     = o_wr_q;
  assign o_rreg   = o_rreg_q;
  assign o_wreg   = o_wreg_q;
  assign o_wdata  = o_wdata_q;
  assign p0_ack   = p0_ack_q;
  assign p1_ack   = p1_ack_q;
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 SHALL have parameter R_ADDR_WIDTH, default 2, register index width.
REQ-002 SHALL have port clk, input, 1, sole clock; all state on posedge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have ports p0_req, p1_req, input, 1, requester N transaction request.
REQ-005 SHALL have ports p0_we, p1_we, input, 1, 1=write, 0=read.
REQ-006 SHALL have ports p0_addr, p1_addr, input, R_ADDR_WIDTH, register index.
REQ-007 SHALL have ports p0_wdata, p1_wdata, input, 32, write data.
REQ-008 SHALL have ports p0_ack, p1_ack, output, 1, one-cycle completion pulse.
REQ-009 SHALL have ports p0_rdata, p1_rdata, output, 32, read data, valid while ack high and held until the next read completes for that port.
REQ-010 SHALL have port o_rd, output, 1, register-file read strobe.
REQ-011 SHALL have port o_rreg, output, R_ADDR_WIDTH, read index.
REQ-012 SHALL have port i_rdata, input, 32, register-file data, sampled on the posedge after o_rd is high.
REQ-013 SHALL have ports o_wr, output, 1, and o_wreg, output, R_ADDR_WIDTH, write strobe and index.
REQ-014 SHALL have port o_wdata, output, 32, write data qualified by o_wr.

Function
REQ-015 SHALL implement an FSM with states IDLE, WRITE, RD_ISSUE and RD_DONE, with all outputs registered.
REQ-016 In IDLE with no request, SHALL remain in IDLE with o_rd, o_wr and both acks at 0.
REQ-017 In IDLE, a granted write SHALL move to WRITE and register o_wr=1, o_wreg=addr, o_wdata=wdata and pN_ack=1 for exactly one cycle.
REQ-018 In IDLE, a granted read SHALL move to RD_ISSUE and register o_rd=1 and o_rreg=addr for exactly one cycle.
REQ-019 In RD_ISSUE, SHALL capture i_rdata into pN_rdata, assert pN_ack for one cycle, drop o_rd and move to RD_DONE.
REQ-020 WRITE and RD_DONE SHALL return to IDLE unconditionally without sampling requests (the ack cycle).
REQ-021 Latency from req sampled to ack high SHALL be 1 cycle for writes and 2 cycles for reads; peak throughput SHALL be one write per 2 cycles and one read per 3 cycles.
REQ-022 Requesters SHALL hold req/we/addr/wdata stable until ack and drop req on the edge that samples ack high; the arbiter SHALL NOT double-issue under this protocol.
REQ-023 If exactly one req is high in IDLE, that port SHALL be granted.
REQ-024 If both reqs are high in IDLE, the port not equal to last_grant SHALL be granted (round-robin); last_grant SHALL update on every grant.
REQ-025 Only the granted port's ack SHALL pulse; p0_ack and p1_ack SHALL never be high together.
REQ-026 o_rd and o_wr SHALL never be high in the same cycle.
REQ-027 o_rreg/o_wreg/o_wdata SHALL hold their last values when their strobes are low.

Reset
REQ-028 When rst_n is low, SHALL immediately force state=IDLE, and o_rd, o_wr, acks, o_rreg, o_wreg, o_wdata and pN_rdata to 0, with last_grant=1 so port 0 wins the first tie.
REQ-029 Reset mid-transaction SHALL abandon it with no ack; the requester SHALL reissue it.
REQ-030 After rst_n rises, the first request SHALL be sampled on the first posedge.

Configuration
REQ-031 With macro REGFILE_ARB_FIXED_PRIO_EN defined, ties SHALL always grant port 0; last_grant SHALL not be implemented.
REQ-032 Without REGFILE_ARB_FIXED_PRIO_EN, SHALL use round-robin per REQ-024.

Verification
REQ-033 Write: p0 write addr=2, wdata=0xDEADBEEF -> next cycle o_wr=1, o_wreg=2, o_wdata=0xDEADBEEF, p0_ack=1; IDLE 2 cycles after request.
REQ-034 Read: p1 read addr=1 with the model returning 0x12345678 -> o_rd=1, o_rreg=1 at +1; p1_ack=1, p1_rdata=0x12345678 at +2; p1_rdata holds afterwards.
REQ-035 Tie: both ports request continuously for 4 transactions after reset -> grant order 0,1,0,1 (0,0,0,0 with REGFILE_ARB_FIXED_PRIO_EN, p1 starved).
REQ-036 Reset: rst_n low during RD_ISSUE -> o_rd=0, no ack, p*_rdata=0 without a clock edge; after release, a reissued read completes normally.
REQ-037 Mixed: p0 write addr=3, 0xA5A5A5A5, then p1 read addr=3 -> p1_rdata=0xA5A5A5A5; o_rd and o_wr never high in the same cycle.
